// File: rtl/exec_unit_pkg.sv
// Shared types and widths for the exec_unit instruction executor.
// Optional MUL support is selected with EXEC_UNIT_MUL_EN (see exec_alu).
package exec_unit_pkg;

  localparam int REG_W = 8;
  localparam int SEL_W = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MOV = 4'd8,
    OP_LDI = 4'd9,
    OP_MUL = 4'd10
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPS  = 2'd1,
    S_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/exec_unit_if.sv
// Instruction handshake, register-file ports and status flags of exec_unit.
// slave = the execution unit, master = the instruction source / register file side.
interface exec_unit_if;
  import exec_unit_pkg::*;

  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       instr_op;
  logic [SEL_W-1:0] instr_rd;
  logic [SEL_W-1:0] instr_rs;
  logic [SEL_W-1:0] instr_rt;
  logic [REG_W-1:0] instr_imm;

  logic [SEL_W-1:0] re_sel_a;
  logic [SEL_W-1:0] re_sel_b;
  logic [REG_W-1:0] re_data_a;
  logic [REG_W-1:0] re_data_b;

  logic [SEL_W-1:0] wr_sel;
  logic [REG_W-1:0] wr_data;
  logic             wr_en;

  logic             flag_z;
  logic             flag_c;
  logic             illegal;

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm,
    input  re_data_a, re_data_b,
    output instr_ready, re_sel_a, re_sel_b,
    output wr_sel, wr_data, wr_en,
    output flag_z, flag_c, illegal
  );

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm,
    output re_data_a, re_data_b,
    input  instr_ready, re_sel_a, re_sel_b,
    input  wr_sel, wr_data, wr_en,
    input  flag_z, flag_c, illegal
  );

endinterface

// File: rtl/exec_unit_alu.sv
// Combinational datapath for exec_unit: result, flags, write-enable and illegal decode.
// MUL is decoded only when EXEC_UNIT_MUL_EN is defined; otherwise it falls to the illegal path.
module exec_alu
  import exec_unit_pkg::*;
(
  input  logic [3:0]       op_i,
  input  logic [REG_W-1:0] a_i,
  input  logic [REG_W-1:0] b_i,
  input  logic [REG_W-1:0] imm_i,
  input  logic             c_i,
  output logic [REG_W-1:0] result_o,
  output logic             z_o,
  output logic             c_o,
  output logic             we_o,
  output logic             illegal_o
);

  logic [REG_W:0] sum;
`ifdef EXEC_UNIT_MUL_EN
  logic [2*REG_W-1:0] prod;
`endif

  always_comb begin
    sum       = {1'b0, a_i} + {1'b0, b_i};
`ifdef EXEC_UNIT_MUL_EN
    prod      = {{REG_W{1'b0}}, a_i} * {{REG_W{1'b0}}, b_i};
`endif
    result_o  = '0;
    c_o       = c_i;
    we_o      = 1'b1;
    illegal_o = 1'b0;
    case (op_i)
      OP_NOP: we_o = 1'b0;
      OP_ADD: begin
        result_o = sum[REG_W-1:0];
        c_o      = sum[REG_W];
      end
      OP_SUB: begin
        result_o = a_i - b_i;
        c_o      = (a_i < b_i);
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_SHL: begin
        result_o = {a_i[REG_W-2:0], 1'b0};
        c_o      = a_i[REG_W-1];
      end
      OP_SHR: begin
        result_o = {1'b0, a_i[REG_W-1:1]};
        c_o      = a_i[0];
      end
      OP_MOV: result_o = a_i;
      OP_LDI: result_o = imm_i;
`ifdef EXEC_UNIT_MUL_EN
      OP_MUL: begin
        result_o = prod[REG_W-1:0];
        c_o      = |prod[2*REG_W-1:REG_W];
      end
`endif
      default: begin
        we_o      = 1'b0;
        illegal_o = 1'b1;
      end
    endcase
  end

  assign z_o = (result_o == '0);

endmodule

// File: rtl/exec_unit.sv
// Three-cycle instruction executor: accept, operand read/compute, write-back.
// MUL support is compiled in with EXEC_UNIT_MUL_EN.
//
// state  | meaning
// S_IDLE | ready for an instruction; fields latched on accept
// S_OPS  | register file read, ALU result and flags registered at exit
// S_WB   | wr_en / illegal presented for one cycle
module exec_unit
  import exec_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  exec_unit_if.slave  bus
);

  state_e           state_q, state_d;
  logic             accept;

  logic [3:0]       op_q;
  logic [SEL_W-1:0] rd_q, rs_q, rt_q;
  logic [REG_W-1:0] imm_q;
  logic [REG_W-1:0] result_q;
  logic             flag_z_q, flag_c_q;
  logic             we_q, illegal_q;

  logic [REG_W-1:0] alu_result;
  logic             alu_z, alu_c, alu_we, alu_illegal;

  exec_alu u_alu (
    .op_i      (op_q),
    .a_i       (bus.re_data_a),
    .b_i       (bus.re_data_b),
    .imm_i     (imm_q),
    .c_i       (flag_c_q),
    .result_o  (alu_result),
    .z_o       (alu_z),
    .c_o       (alu_c),
    .we_o      (alu_we),
    .illegal_o (alu_illegal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    bus.instr_ready = 1'b0;
    bus.wr_en       = 1'b0;
    bus.illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          accept  = 1'b1;
          state_d = S_OPS;
        end
      end
      S_OPS: state_d = S_WB;
      S_WB: begin
        bus.wr_en   = we_q;
        bus.illegal = illegal_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flags only move for writing ops; NOP and illegal opcodes keep them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      result_q  <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.instr_op;
        rd_q  <= bus.instr_rd;
        rs_q  <= bus.instr_rs;
        rt_q  <= bus.instr_rt;
        imm_q <= bus.instr_imm;
      end
      if (state_q == S_OPS) begin
        result_q  <= alu_result;
        we_q      <= alu_we;
        illegal_q <= alu_illegal;
        if (alu_we) begin
          flag_z_q <= alu_z;
          flag_c_q <= alu_c;
        end
      end
    end
  end

  assign bus.re_sel_a = rs_q;
  assign bus.re_sel_b = rt_q;
  assign bus.wr_sel   = rd_q;
  assign bus.wr_data  = result_q;
  assign bus.flag_z   = flag_z_q;
  assign bus.flag_c   = flag_c_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural 8x8 register file.
module tb_exec_unit;
  import exec_unit_pkg::*;

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, rs, rt;
    logic [7:0] imm;
    bit         hold;
    bit         we;
    logic [7:0] data;
    bit         z, c, ill;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  logic [7:0] rf [8];
  logic [7:0] exp_rf [8];

  exec_unit_if bus ();

  exec_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  assign bus.re_data_a = rf[bus.re_sel_a];
  assign bus.re_data_b = rf[bus.re_sel_b];

  always @(posedge clock) if (bus.wr_en) rf[bus.wr_sel] <= bus.wr_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [2:0] rd, rs, rt, input logic [7:0] imm,
                     input bit hold, input bit we, input logic [7:0] data,
                     input bit z, input bit c, input bit ill);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.imm = imm; v.hold = hold;
    v.we = we; v.data = data; v.z = z; v.c = c; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic run(input vec_t v);
    @(negedge clock);
    check("ready_idle", 32'(bus.instr_ready), 32'(1));
    bus.instr_valid = 1'b1;
    bus.instr_op    = v.op;
    bus.instr_rd    = v.rd;
    bus.instr_rs    = v.rs;
    bus.instr_rt    = v.rt;
    bus.instr_imm   = v.imm;
    @(posedge clock); #1;
    if (v.hold) begin
      bus.instr_op  = OP_LDI;
      bus.instr_rd  = 3'd7;
      bus.instr_rs  = 3'd0;
      bus.instr_rt  = 3'd0;
      bus.instr_imm = 8'h33;
    end else begin
      bus.instr_valid = 1'b0;
    end
    check("ops_ready", 32'(bus.instr_ready), 32'(0));
    check("ops_wr_en", 32'(bus.wr_en), 32'(0));
    check("ops_sel_a", 32'(bus.re_sel_a), 32'(v.rs));
    check("ops_sel_b", 32'(bus.re_sel_b), 32'(v.rt));
    @(posedge clock); #1;
    check("wb_wr_en", 32'(bus.wr_en), 32'(v.we));
    check("wb_illegal", 32'(bus.illegal), 32'(v.ill));
    check("wb_flag_z", 32'(bus.flag_z), 32'(v.z));
    check("wb_flag_c", 32'(bus.flag_c), 32'(v.c));
    if (v.we) begin
      check("wb_wr_sel", 32'(bus.wr_sel), 32'(v.rd));
      check("wb_wr_data", 32'(bus.wr_data), 32'(v.data));
    end
    @(posedge clock); #1;
    bus.instr_valid = 1'b0;
    check("done_ready", 32'(bus.instr_ready), 32'(1));
    check("done_wr_en", 32'(bus.wr_en), 32'(0));
    check("done_illegal", 32'(bus.illegal), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op    = '0;
    bus.instr_rd    = '0;
    bus.instr_rs    = '0;
    bus.instr_rt    = '0;
    bus.instr_imm   = '0;

    //     op      rd    rs    rt    imm    hold we  data   z  c  ill
    add(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hF0, 0, 1, 8'hF0, 0, 0, 0);
    add(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h20, 0, 1, 8'h20, 0, 0, 0);
    add(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 0, 1, 8'h10, 0, 1, 0);
    add(OP_LDI, 3'd4, 3'd0, 3'd0, 8'h05, 0, 1, 8'h05, 0, 1, 0);
    add(OP_SUB, 3'd4, 3'd4, 3'd4, 8'h00, 0, 1, 8'h00, 1, 0, 0);
    add(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h01, 0, 1, 8'h01, 0, 0, 0);
    add(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h02, 0, 1, 8'h02, 0, 0, 0);
    add(OP_SUB, 3'd7, 3'd1, 3'd2, 8'h00, 0, 1, 8'hFF, 0, 1, 0);
    add(OP_LDI, 3'd4, 3'd0, 3'd0, 8'hA5, 1, 1, 8'hA5, 0, 1, 0);
    add(OP_MOV, 3'd5, 3'd4, 3'd0, 8'h00, 0, 1, 8'hA5, 0, 1, 0);
    add(OP_AND, 3'd6, 3'd5, 3'd7, 8'h00, 0, 1, 8'hA5, 0, 1, 0);
    add(OP_OR,  3'd6, 3'd3, 3'd1, 8'h00, 0, 1, 8'h11, 0, 1, 0);
    add(OP_XOR, 3'd0, 3'd7, 3'd7, 8'h00, 0, 1, 8'h00, 1, 1, 0);
    add(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h81, 0, 1, 8'h81, 0, 1, 0);
    add(OP_SHL, 3'd2, 3'd1, 3'd0, 8'h00, 0, 1, 8'h02, 0, 1, 0);
    add(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h40, 0, 1, 8'h40, 0, 1, 0);
    add(OP_SHL, 3'd2, 3'd1, 3'd0, 8'h00, 0, 1, 8'h80, 0, 0, 0);
    add(OP_SHR, 3'd3, 3'd1, 3'd0, 8'h00, 0, 1, 8'h20, 0, 0, 0);
    add(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h01, 0, 1, 8'h01, 0, 0, 0);
    add(OP_SHR, 3'd3, 3'd1, 3'd0, 8'h00, 0, 1, 8'h00, 1, 1, 0);
    add(OP_ADD, 3'd6, 3'd7, 3'd2, 8'h00, 0, 1, 8'h7F, 0, 1, 0);
    add(4'hF,   3'd5, 3'd7, 3'd7, 8'h00, 0, 0, 8'h00, 0, 1, 1);
    add(OP_NOP, 3'd5, 3'd7, 3'd7, 8'h00, 0, 0, 8'h00, 0, 1, 0);
    add(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h10, 0, 1, 8'h10, 0, 1, 0);
    add(OP_SHL, 3'd3, 3'd1, 3'd0, 8'h00, 0, 1, 8'h20, 0, 0, 0);
`ifdef EXEC_UNIT_MUL_EN
    add(OP_MUL, 3'd2, 3'd1, 3'd1, 8'h00, 0, 1, 8'h00, 1, 1, 0);
    add(4'hB,   3'd2, 3'd1, 3'd1, 8'h00, 0, 0, 8'h00, 1, 1, 1);
`else
    add(OP_MUL, 3'd2, 3'd1, 3'd1, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    add(4'hB,   3'd2, 3'd1, 3'd1, 8'h00, 0, 0, 8'h00, 0, 0, 1);
`endif

    exp_rf[0] = 8'h00; exp_rf[1] = 8'h10; exp_rf[3] = 8'h20; exp_rf[4] = 8'hA5;
    exp_rf[5] = 8'hA5; exp_rf[6] = 8'h7F; exp_rf[7] = 8'hFF;
`ifdef EXEC_UNIT_MUL_EN
    exp_rf[2] = 8'h00;
`else
    exp_rf[2] = 8'h80;
`endif

    #2;
    check("rst_ready", 32'(bus.instr_ready), 32'(1));
    check("rst_wr_en", 32'(bus.wr_en), 32'(0));
    check("rst_illegal", 32'(bus.illegal), 32'(0));
    check("rst_flag_z", 32'(bus.flag_z), 32'(0));
    check("rst_flag_c", 32'(bus.flag_c), 32'(0));
    check("rst_wr_data", 32'(bus.wr_data), 32'(0));
    check("rst_wr_sel", 32'(bus.wr_sel), 32'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) run(vecs[i]);

    for (int r = 0; r < 8; r++) check($sformatf("rf_r%0d", r), 32'(rf[r]), 32'(exp_rf[r]));

    // ADD R4+R5 = 0xA5+0xA5 -> carry set at WB, then reset mid write-back.
    @(negedge clock);
    bus.instr_valid = 1'b1;
    bus.instr_op    = OP_ADD;
    bus.instr_rd    = 3'd6;
    bus.instr_rs    = 3'd4;
    bus.instr_rt    = 3'd5;
    bus.instr_imm   = 8'h00;
    @(posedge clock); #1;
    bus.instr_valid = 1'b0;
    @(posedge clock); #1;
    check("abort_pre_wr_en", 32'(bus.wr_en), 32'(1));
    check("abort_pre_flag_c", 32'(bus.flag_c), 32'(1));
    reset_n = 1'b0;
    #1;
    check("abort_wr_en", 32'(bus.wr_en), 32'(0));
    check("abort_flag_c", 32'(bus.flag_c), 32'(0));
    check("abort_flag_z", 32'(bus.flag_z), 32'(0));
    check("abort_illegal", 32'(bus.illegal), 32'(0));
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("abort_ready", 32'(bus.instr_ready), 32'(1));
    check("abort_r6", 32'(rf[6]), 32'(8'h7F));
    @(posedge clock); #1;
    check("abort_idle_wr_en", 32'(bus.wr_en), 32'(0));
    check("abort_idle_ready", 32'(bus.instr_ready), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: instr_valid  in  1  instruction offered; instr_ready  out  1  unit can accept.
REQ-004 SHALL have ports: instr_op  in  4  opcode; instr_rd/instr_rs/instr_rt  in  3 each  dest/src-A/src-B register; instr_imm  in  8  immediate.
REQ-005 SHALL have ports: re_sel_a, re_sel_b  out  3  register-file read selects; re_data_a, re_data_b  in  8  combinational read data.
REQ-006 SHALL have ports: wr_sel  out  3, wr_data  out  8, wr_en  out  1  register-file write port.
REQ-007 SHALL have ports: flag_z, flag_c  out  1 each  result flags; illegal  out  1  one-cycle illegal-opcode pulse.
REQ-008 Clock/reset SHALL be one clock `clock`; reset `reset_n` asynchronous, active-low.

Function
REQ-009 FSM states SHALL be IDLE, OPS, WB; IDLE->OPS on instr_valid&&instr_ready; OPS->WB always; WB->IDLE always.
REQ-010 instr_ready SHALL be 1 only in IDLE; instr_valid in OPS/WB ignored, nothing latched.
REQ-011 On accept, op/rd/rs/rt/imm SHALL be latched; re_sel_a=latched rs, re_sel_b=latched rt at all times.
REQ-012 In OPS, result and next flags SHALL be computed from re_data_a (A), re_data_b (B), imm and registered on OPS->WB edge.
REQ-013 Ops: ADD A+B; SUB A-B; AND; OR; XOR; SHL A<<1; SHR A>>1 logical; MOV A; LDI imm; NOP; MUL A*B low byte (REQ-025); all results 8-bit, wrap modulo 256.
REQ-014 flag_c: ADD carry-out; SUB borrow (A<B); SHL A[7]; SHR A[0]; MUL |high byte; all other ops leave flag_c unchanged.
REQ-015 flag_z SHALL be (result==0) for every writing op; NOP/illegal leave both flags unchanged.
REQ-016 wr_en SHALL be 1 exactly during WB for writing ops, 0 otherwise; wr_sel=latched rd, wr_data=registered result.
REQ-017 Latency: accept at edge N -> wr_en high cycle N+2 -> instr_ready high cycle N+3; throughput one instruction per 3 cycles.
REQ-018 No forwarding needed: a dependent instruction's OPS follows the producing WB write edge; rd==rs/rt of same instruction reads old value.
REQ-019 Undefined opcode SHALL behave as NOP and assert illegal for exactly the WB cycle.
REQ-020 Writes to any register index including 0 SHALL be permitted.

Reset
REQ-021 reset_n low SHALL immediately force IDLE, wr_en=0, illegal=0, flag_z=0, flag_c=0, latched fields and result=0.
REQ-022 Reset asserted in OPS or WB SHALL abort the instruction with no write performed; instr_ready=1 first cycle after release.

Configuration
REQ-023 Macro EXEC_UNIT_MUL_EN SHALL gate the MUL opcode.
REQ-024 Without EXEC_UNIT_MUL_EN, MUL SHALL be undefined: NOP behaviour plus illegal pulse; no multiplier logic synthesized.
REQ-025 With EXEC_UNIT_MUL_EN, MUL SHALL complete in the same 3-cycle schedule as other ops.

Structure
REQ-026 Shared package SHALL hold the opcode enum (4-bit: NOP=0, ADD, SUB, AND, OR, XOR, SHL, SHR, MOV, LDI, MUL=10), FSM state enum, and REG_W=8, SEL_W=3 constants.
REQ-027 Datapath SHALL be one sub-module exec_alu (combinational: op, A, B, imm, carry-in -> result, z, c); FSM and registers stay in exec_unit.

Verification
REQ-028 ADD rd=3 rs=1 rt=2 with R1=0xF0, R2=0x20 -> WB: wr_sel=3, wr_data=0x10, flag_c=1, flag_z=0; wr_en cycle N+2.
REQ-029 SUB with A=0x05, B=0x05 -> wr_data=0x00, flag_z=1, flag_c=0; then SUB A=0x01, B=0x02 -> 0xFF, flag_c=1.
REQ-030 LDI rd=4 imm=0xA5 then MOV rd=5 rs=4 -> R5=0xA5 with no stall/forwarding; instr_valid held high during OPS/WB accepts nothing extra.
REQ-031 Opcode 0xF -> wr_en stays 0, illegal=1 for one cycle, flags unchanged; MUL 0x10*0x10 -> illegal without macro, 0x00 with flag_c=1 with macro.
REQ-032 Assert reset_n low during WB of ADD -> wr_en drops at once, register unchanged, flags 0, instr_ready=1 after release.
